// File: rtl/piano_tone_scheduler.sv
// ============================================================================
// Module   : piano_tone_scheduler
// Brief    : Debounced 12-key monophonic scheduler driving a glitch-free
//            programmable half-period square-wave divider.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module piano_tone_scheduler #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int DB_W         = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] keys,
  input  logic [1:0]  oct_sel,
  output logic        tone_out,
  output logic        playing,
  output logic [3:0]  note_idx,
  output logic [16:0] half_period
);

  localparam logic [DB_W-1:0] c_db_last = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_STOP = 2'd2
  } state_t;

  logic [11:0] r_keys_s1, r_keys_s2;
  logic [1:0]  r_oct_s1, r_oct_s2;
  logic [11:0] w_deb;
  logic [3:0]  w_sel;
  logic        w_any;
  logic        r_sel_valid;
  logic [3:0]  r_sel_hold;
  logic [16:0] w_base, w_hp_new;

  state_t      r_state, w_state_nx;
  logic [16:0] r_cnt, w_cnt_nx;
  logic [16:0] r_hp, w_hp_nx;
  logic        r_tone, w_tone_nx;
  logic        w_boundary;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_keys_s1 <= '0;
      r_keys_s2 <= '0;
      r_oct_s1  <= '0;
      r_oct_s2  <= '0;
    end else begin
      r_keys_s1 <= keys;
      r_keys_s2 <= r_keys_s1;
      r_oct_s1  <= oct_sel;
      r_oct_s2  <= r_oct_s1;
    end
  end

  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_deb
      logic [DB_W-1:0] r_db_cnt;
      logic            r_db_bit;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_db_cnt <= '0;
          r_db_bit <= 1'b0;
        end else if (r_keys_s2[gi] == r_db_bit) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == c_db_last) begin
          r_db_cnt <= '0;
          r_db_bit <= r_keys_s2[gi];
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end

      assign w_deb[gi] = r_db_bit;
    end
  endgenerate

  // Highest set index wins; later iterations override earlier ones.
  always_comb begin
    w_sel = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_deb[i]) w_sel = 4'(i);
    end
  end

  assign w_any = |w_deb;

  // r_sel_hold keeps the last valid note so a release can still retune sanely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_valid <= 1'b0;
      note_idx    <= 4'd0;
      r_sel_hold  <= 4'd0;
    end else begin
      r_sel_valid <= w_any;
      note_idx    <= w_sel;
      if (w_any) r_sel_hold <= w_sel;
    end
  end

  always_comb begin
    w_base = 17'd47778;
    case (r_sel_hold)
      4'd0:    w_base = 17'd47778;
      4'd1:    w_base = 17'd45096;
      4'd2:    w_base = 17'd42565;
      4'd3:    w_base = 17'd40176;
      4'd4:    w_base = 17'd37921;
      4'd5:    w_base = 17'd35793;
      4'd6:    w_base = 17'd33784;
      4'd7:    w_base = 17'd31888;
      4'd8:    w_base = 17'd30098;
      4'd9:    w_base = 17'd28409;
      4'd10:   w_base = 17'd26814;
      4'd11:   w_base = 17'd25309;
      default: w_base = 17'd47778;
    endcase
  end

  always_comb begin
    w_hp_new = w_base;
    case (r_oct_s2)
      2'd0:    w_hp_new = {w_base[15:0], 1'b0};
      2'd1:    w_hp_new = w_base;
      2'd2:    w_hp_new = w_base >> 1;
      default: w_hp_new = w_base >> 2;
    endcase
  end

  assign w_boundary = (r_cnt == r_hp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hp    <= '0;
      r_tone  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_hp    <= w_hp_nx;
      r_tone  <= w_tone_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 17'd1;
    w_hp_nx    = r_hp;
    w_tone_nx  = r_tone;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx  = '0;
        w_hp_nx   = '0;
        w_tone_nx = 1'b0;
        if (r_sel_valid) begin
          w_hp_nx    = w_hp_new;
          w_tone_nx  = 1'b1;
          w_state_nx = S_PLAY;
        end
      end
      S_PLAY: begin
        // Retune only at the half-period edge so the waveform never glitches.
        if (w_boundary) begin
          w_cnt_nx  = '0;
          w_tone_nx = ~r_tone;
          w_hp_nx   = w_hp_new;
        end
        if (!r_sel_valid) w_state_nx = S_STOP;
      end
      S_STOP: begin
        if (w_boundary) begin
          w_cnt_nx   = '0;
          w_tone_nx  = 1'b0;
          w_hp_nx    = '0;
          w_state_nx = S_IDLE;
        end else if (r_sel_valid) begin
          w_state_nx = S_PLAY;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_hp_nx    = '0;
        w_tone_nx  = 1'b0;
      end
    endcase
  end

  assign tone_out    = r_tone;
  assign playing     = (r_state != S_IDLE);
  assign half_period = r_hp;

endmodule

`default_nettype wire

// File: tb/tb_piano_tone_scheduler.sv
// Testbench for piano_tone_scheduler with DEBOUNCE_CYC = 4; expectations come
// from a note/octave model and cycle timing derived from the divider rules.
`timescale 1ns/1ps
`default_nettype none

module tb_piano_tone_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] keys = '0;
  logic [1:0]  oct_sel = '0;
  logic        tone_out;
  logic        playing;
  logic [3:0]  note_idx;
  logic [16:0] half_period;

  int checks = 0;
  int errors = 0;

  int base_hp [12] = '{47778, 45096, 42565, 40176, 37921, 35793,
                       33784, 31888, 30098, 28409, 26814, 25309};

  always #5 clk = ~clk;

  piano_tone_scheduler #(
    .DEBOUNCE_CYC(4),
    .DB_W        (19)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keys       (keys),
    .oct_sel    (oct_sel),
    .tone_out   (tone_out),
    .playing    (playing),
    .note_idx   (note_idx),
    .half_period(half_period)
  );

  function automatic int model_note(input logic [11:0] k);
    int n = 0;
    for (int i = 0; i < 12; i++) if (k[i]) n = i;
    return n;
  endfunction

  function automatic int model_hp(input int note, input int oct);
    int b = base_hp[note];
    case (oct)
      0:       return b * 2;
      1:       return b;
      2:       return b / 2;
      default: return b / 4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    keys  = '0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_playing(output int n);
    n = 0;
    while (playing !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_toggle(input int bound, output int n);
    logic prev;
    prev = tone_out;
    n = 0;
    while (tone_out === prev && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; keys = '0; oct_sel = 2'd0;
    repeat (3) tick();
    checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL reset_tone: got %0b expected 0", tone_out); end
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %0b expected 0", playing); end
    checks++; if (note_idx !== 4'd0) begin errors++; $display("FAIL reset_note: got %0d expected 0", note_idx); end
    checks++; if (half_period !== 17'd0) begin errors++; $display("FAIL reset_hp: got %0d expected 0", half_period); end
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %0b expected 0", playing); end
  endtask

  task automatic test_single_key();
    int n, hp;
    do_reset();
    oct_sel = 2'd1;
    keys    = 12'h200;
    hp      = model_hp(9, 1);
    repeat (7) tick();
    checks++; if (note_idx !== 4'd9) begin errors++; $display("FAIL a_note_latency: got %0d expected 9", note_idx); end
    wait_playing(n);
    checks++; if (playing !== 1'b1) begin errors++; $display("FAIL a_playing: got %0b expected 1", playing); end
    checks++; if (half_period !== 17'(hp)) begin errors++; $display("FAIL a_hp: got %0d expected %0d", half_period, hp); end
    checks++; if (tone_out !== 1'b1) begin errors++; $display("FAIL a_tone_start: got %0b expected 1", tone_out); end
    wait_toggle(40000, n);
    checks++; if (n != hp + 1) begin errors++; $display("FAIL a_half_period_len: got %0d expected %0d", n, hp + 1); end
    checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL a_tone_toggle: got %0b expected 0", tone_out); end
    do_reset();
  endtask

  task automatic test_bounce();
    int len, gap;
    do_reset();
    oct_sel = 2'd1;
    for (int p = 0; p < 20; p++) begin
      len  = $urandom_range(1, 3);
      gap  = $urandom_range(1, 3);
      keys = 12'h001;
      for (int c = 0; c < len + gap; c++) begin
        if (c == len) keys = 12'h000;
        tick();
        checks++;
        if (playing !== 1'b0 || note_idx !== 4'd0) begin
          errors++;
          $display("FAIL bounce: got playing=%0b note=%0d expected playing=0 note=0", playing, note_idx);
        end
      end
    end
    repeat (10) tick();
    checks++; if (playing !== 1'b0) begin errors++; $display("FAIL bounce_settle: got %0b expected 0", playing); end
  endtask

  task automatic test_retune();
    int n, el, hp_old, hp_new;
    do_reset();
    oct_sel = 2'd3;
    keys    = 12'h001;
    hp_old  = model_hp(0, 3);
    hp_new  = model_hp(4, 3);
    wait_playing(n);
    checks++; if (half_period !== 17'(hp_old)) begin errors++; $display("FAIL rt_hp_c: got %0d expected %0d", half_period, hp_old); end
    repeat (100) tick();
    keys = 12'h011;
    repeat (6) tick();
    checks++; if (note_idx !== 4'd0) begin errors++; $display("FAIL rt_note_early: got %0d expected 0", note_idx); end
    tick();
    el = 107;
    checks++; if (note_idx !== 4'd4) begin errors++; $display("FAIL rt_note_e: got %0d expected 4", note_idx); end
    checks++; if (half_period !== 17'(hp_old)) begin errors++; $display("FAIL rt_hp_frozen: got %0d expected %0d", half_period, hp_old); end
    wait_toggle(20000, n);
    checks++; if (el + n != hp_old + 1) begin errors++; $display("FAIL rt_first_edge: got %0d expected %0d", el + n, hp_old + 1); end
    checks++; if (half_period !== 17'(hp_new)) begin errors++; $display("FAIL rt_hp_new: got %0d expected %0d", half_period, hp_new); end
    wait_toggle(20000, n);
    checks++; if (n != hp_new + 1) begin errors++; $display("FAIL rt_new_len: got %0d expected %0d", n, hp_new + 1); end
    do_reset();
  endtask

  task automatic test_stop();
    int n, hp, changes;
    logic prev;
    do_reset();
    oct_sel = 2'd3;
    keys    = 12'h800;
    hp      = model_hp(11, 3);
    wait_playing(n);
    checks++; if (half_period !== 17'(hp)) begin errors++; $display("FAIL st_hp: got %0d expected %0d", half_period, hp); end
    keys = 12'h000;
    repeat (10) tick();
    checks++; if (playing !== 1'b1 || tone_out !== 1'b1) begin errors++; $display("FAIL st_hold: got playing=%0b tone=%0b expected 1 1", playing, tone_out); end
    checks++; if (note_idx !== 4'd0) begin errors++; $display("FAIL st_note: got %0d expected 0", note_idx); end
    wait_toggle(20000, n);
    checks++; if (10 + n != hp + 1) begin errors++; $display("FAIL st_edge_time: got %0d expected %0d", 10 + n, hp + 1); end
    checks++; if (tone_out !== 1'b0 || playing !== 1'b0) begin errors++; $display("FAIL st_end: got tone=%0b playing=%0b expected 0 0", tone_out, playing); end
    checks++; if (half_period !== 17'd0) begin errors++; $display("FAIL st_hp_idle: got %0d expected 0", half_period); end
    changes = 0;
    prev = tone_out;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (tone_out !== prev || playing !== 1'b0) changes++;
      prev = tone_out;
    end
    checks++; if (changes != 0) begin errors++; $display("FAIL st_quiet: got %0d extra events expected 0", changes); end
  endtask

  task automatic test_octave_reset();
    int n;
    do_reset();
    oct_sel = 2'd3;
    keys    = 12'h800;
    wait_playing(n);
    checks++; if (half_period !== 17'd6327) begin errors++; $display("FAIL b_oct7: got %0d expected 6327", half_period); end
    repeat (50) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (tone_out !== 1'b0 || playing !== 1'b0 || note_idx !== 4'd0 || half_period !== 17'd0) begin
      errors++;
      $display("FAIL async_reset_b: got tone=%0b playing=%0b note=%0d hp=%0d expected all 0",
               tone_out, playing, note_idx, half_period);
    end
    do_reset();
    oct_sel = 2'd0;
    keys    = 12'h001;
    wait_playing(n);
    checks++; if (half_period !== 17'd95556) begin errors++; $display("FAIL c_oct4: got %0d expected 95556", half_period); end
    checks++; if (note_idx !== 4'd0 || playing !== 1'b1) begin errors++; $display("FAIL c_oct4_state: got note=%0d playing=%0b expected 0 1", note_idx, playing); end
    repeat (30) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (tone_out !== 1'b0 || playing !== 1'b0 || half_period !== 17'd0) begin
      errors++;
      $display("FAIL async_reset_c: got tone=%0b playing=%0b hp=%0d expected all 0", tone_out, playing, half_period);
    end
    do_reset();
  endtask

  task automatic test_random();
    int n, hp, note, oct;
    logic [11:0] k;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      k    = 12'($urandom_range(1, 4095));
      oct  = (it == 0) ? 3 : int'($urandom_range(0, 3));
      note = model_note(k);
      hp   = model_hp(note, oct);
      oct_sel = 2'(oct);
      keys    = k;
      wait_playing(n);
      checks++; if (playing !== 1'b1) begin errors++; $display("FAIL rnd_playing: keys=%h got %0b expected 1", k, playing); end
      checks++; if (note_idx !== 4'(note)) begin errors++; $display("FAIL rnd_note: keys=%h got %0d expected %0d", k, note_idx, note); end
      checks++; if (half_period !== 17'(hp)) begin errors++; $display("FAIL rnd_hp: keys=%h oct=%0d got %0d expected %0d", k, oct, half_period, hp); end
      if (it == 0) begin
        wait_toggle(20000, n);
        checks++; if (n != hp + 1) begin errors++; $display("FAIL rnd_len: got %0d expected %0d", n, hp + 1); end
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_retune();
    test_stop();
    test_octave_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
